// File: rtl/multiport_adder_tree.sv
// Pipelined signed adder tree over NPORTS masked lanes, with per-beat accumulate
// mode and optional output saturation. Latency LEVELS+1, one beat per cycle.
module multiport_adder_tree #(
  parameter int unsigned NPORTS    = 3,
  parameter int unsigned WIDTH     = 19,
  parameter int unsigned OUT_WIDTH = WIDTH + $clog2(NPORTS) + 4,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         port_iv,
  input  logic [NPORTS-1:0][WIDTH-1:0] port_id,
  input  logic [NPORTS-1:0]            port_mask,
  input  logic                         port_ilast,
  input  logic                         acc_en,
  output logic                         sum_ov,
  output logic [OUT_WIDTH-1:0]         sum_od,
  output logic                         sum_olast,
  output logic                         sum_osat
);

  localparam int unsigned LEVELS = $clog2(NPORTS);
  localparam int unsigned TREE_W = WIDTH + LEVELS;
  localparam int unsigned PAD    = 1 << LEVELS;

  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  if (NPORTS < 2) begin : g_bad_nports
    $error("multiport_adder_tree: NPORTS must be at least 2");
  end
  if (OUT_WIDTH < TREE_W) begin : g_bad_out_width
    $error("multiport_adder_tree: OUT_WIDTH must be at least WIDTH+LEVELS");
  end

  logic signed [TREE_W-1:0] lane [PAD];

  for (genvar i = 0; i < PAD; i++) begin : g_lane
    if (i < NPORTS) begin : g_real
      assign lane[i] = (port_iv && port_mask[i]) ? TREE_W'($signed(port_id[i])) : '0;
    end else begin : g_pad
      assign lane[i] = '0;
    end
  end

  // Heap-ordered tree: node 1 is the root, node n sums nodes 2n and 2n+1,
  // and nodes at the bottom level sum pairs of prepared lanes.
  logic signed [TREE_W-1:0] node_q [1:PAD-1];

  for (genvar n = 1; n < PAD; n++) begin : g_node
    if (2 * n >= PAD) begin : g_bottom
      always_ff @(posedge clk or posedge rst) begin
        if (rst) node_q[n] <= '0;
        else     node_q[n] <= lane[2*n-PAD] + lane[2*n+1-PAD];
      end
    end else begin : g_inner
      always_ff @(posedge clk or posedge rst) begin
        if (rst) node_q[n] <= '0;
        else     node_q[n] <= node_q[2*n] + node_q[2*n+1];
      end
    end
  end

  logic [LEVELS-1:0] vld_q, last_q, acc_q_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      last_q   <= '0;
      acc_q_en <= '0;
    end else begin
      vld_q    <= (vld_q << 1) | LEVELS'(port_iv);
      last_q   <= (last_q << 1) | LEVELS'(port_ilast);
      acc_q_en <= (acc_q_en << 1) | LEVELS'(acc_en);
    end
  end

  logic                        t_vld, t_last, t_acc;
  logic signed [OUT_WIDTH-1:0] t_ext, acc_q, acc_sum;
  logic signed [OUT_WIDTH:0]   wide_sum;
  logic                        sticky_q, ovf;

  assign t_vld  = vld_q[LEVELS-1];
  assign t_last = last_q[LEVELS-1];
  assign t_acc  = acc_q_en[LEVELS-1];
  assign t_ext  = OUT_WIDTH'(node_q[1]);

  // One extra bit exposes overflow as a mismatch of the top two bits.
  always_comb begin
    wide_sum = (OUT_WIDTH+1)'(acc_q) + (OUT_WIDTH+1)'(t_ext);
    acc_sum  = wide_sum[OUT_WIDTH-1:0];
    ovf      = 1'b0;
    if (SATURATE && (wide_sum[OUT_WIDTH] != wide_sum[OUT_WIDTH-1])) begin
      ovf     = 1'b1;
      acc_sum = wide_sum[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      sum_ov    <= 1'b0;
      sum_od    <= '0;
      sum_olast <= 1'b0;
      sum_osat  <= 1'b0;
    end else begin
      sum_ov    <= 1'b0;
      sum_olast <= 1'b0;
      sum_osat  <= 1'b0;
      if (t_vld) begin
        if (!t_acc) begin
          // Pass-through also abandons any open group.
          sum_od    <= t_ext;
          sum_ov    <= 1'b1;
          sum_olast <= 1'b1;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end else if (!t_last) begin
          acc_q    <= acc_sum;
          sticky_q <= sticky_q | ovf;
        end else begin
          sum_od    <= acc_sum;
          sum_ov    <= 1'b1;
          sum_olast <= 1'b1;
          sum_osat  <= sticky_q | ovf;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_adder_tree.sv
// Randomised and directed bench for multiport_adder_tree: three instances share
// stimulus and are compared every cycle against a beat-level reference model.
module tb_multiport_adder_tree;

  localparam int NP = 3;
  localparam int W  = 19;
  localparam int LV = 2;

  logic clk = 1'b0;
  logic rst;
  logic port_iv, port_ilast, acc_en;
  logic [NP-1:0][W-1:0] port_id;
  logic [NP-1:0] port_mask;

  logic ov0, ol0, os0, ov1, ol1, os1, ov2, ol2, os2;
  logic [24:0] od0;
  logic [20:0] od1, od2;

  always #5 clk = ~clk;

  multiport_adder_tree #(.NPORTS(3), .WIDTH(19), .OUT_WIDTH(25), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .port_iv(port_iv), .port_id(port_id), .port_mask(port_mask),
    .port_ilast(port_ilast), .acc_en(acc_en),
    .sum_ov(ov0), .sum_od(od0), .sum_olast(ol0), .sum_osat(os0)
  );

  multiport_adder_tree #(.NPORTS(3), .WIDTH(19), .OUT_WIDTH(21), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .port_iv(port_iv), .port_id(port_id), .port_mask(port_mask),
    .port_ilast(port_ilast), .acc_en(acc_en),
    .sum_ov(ov1), .sum_od(od1), .sum_olast(ol1), .sum_osat(os1)
  );

  multiport_adder_tree #(.NPORTS(3), .WIDTH(19), .OUT_WIDTH(21), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .port_iv(port_iv), .port_id(port_id), .port_mask(port_mask),
    .port_ilast(port_ilast), .acc_en(acc_en),
    .sum_ov(ov2), .sum_od(od2), .sum_olast(ol2), .sum_osat(os2)
  );

  typedef struct {
    bit     v;
    bit     a;
    bit     l;
    longint t;
  } beat_t;

  beat_t  pipe[$];
  int     lanes[NP];
  int     ow_m[3]  = '{25, 21, 21};
  bit     sat_m[3] = '{1'b0, 1'b1, 1'b0};
  longint acc_m[3], od_m[3];
  bit     sticky_m[3], ov_m[3], last_m[3], osat_m[3];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint wrap_to(input longint x, input int ow);
    longint m, r;
    m = longint'(1) << ow;
    r = x & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_reset();
    beat_t idle_b;
    idle_b = '{v: 1'b0, a: 1'b0, l: 1'b0, t: 0};
    pipe.delete();
    for (int i = 0; i < LV; i++) pipe.push_back(idle_b);
    for (int k = 0; k < 3; k++) begin
      acc_m[k] = 0; od_m[k] = 0; sticky_m[k] = 0;
      ov_m[k] = 0; last_m[k] = 0; osat_m[k] = 0;
    end
  endtask

  task automatic model_out(input beat_t b);
    longint s, hi, lo;
    bit     o;
    for (int k = 0; k < 3; k++) begin
      ov_m[k] = 0; last_m[k] = 0; osat_m[k] = 0;
      if (b.v) begin
        if (!b.a) begin
          od_m[k] = b.t; ov_m[k] = 1; last_m[k] = 1;
          acc_m[k] = 0; sticky_m[k] = 0;
        end else begin
          hi = (longint'(1) << (ow_m[k] - 1)) - 1;
          lo = -(longint'(1) << (ow_m[k] - 1));
          s  = acc_m[k] + b.t;
          o  = 0;
          if (sat_m[k]) begin
            if (s > hi) begin s = hi; o = 1; end
            if (s < lo) begin s = lo; o = 1; end
          end else begin
            s = wrap_to(s, ow_m[k]);
          end
          if (!b.l) begin
            acc_m[k] = s; sticky_m[k] = sticky_m[k] | o;
          end else begin
            od_m[k] = s; ov_m[k] = 1; last_m[k] = 1;
            osat_m[k] = sticky_m[k] | o;
            acc_m[k] = 0; sticky_m[k] = 0;
          end
        end
      end
    end
  endtask

  function automatic longint dut_od(input int k);
    longint r;
    case (k)
      0:       r = $signed(od0);
      1:       r = $signed(od1);
      default: r = $signed(od2);
    endcase
    return r;
  endfunction

  function automatic logic [2:0] dut_flags(input int k);
    case (k)
      0:       return {ov0, ol0, os0};
      1:       return {ov1, ol1, os1};
      default: return {ov2, ol2, os2};
    endcase
  endfunction

  // Presents the current inputs for one clock, advances the model, then compares.
  task automatic step();
    beat_t      b;
    logic [2:0] f;
    b.v = port_iv; b.a = acc_en; b.l = port_ilast; b.t = 0;
    if (port_iv) for (int i = 0; i < NP; i++) if (port_mask[i]) b.t += lanes[i];
    pipe.push_back(b);
    @(posedge clk);
    if (rst) model_reset();
    else     model_out(pipe.pop_front());
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      f = dut_flags(k);
      check($sformatf("u%0d_ov", k),    longint'(f[2]), longint'(ov_m[k]));
      check($sformatf("u%0d_olast", k), longint'(f[1]), longint'(last_m[k]));
      check($sformatf("u%0d_osat", k),  longint'(f[0]), longint'(osat_m[k]));
      check($sformatf("u%0d_od", k),    dut_od(k),      od_m[k]);
    end
  endtask

  task automatic beat(input int a0, input int a1, input int a2, input logic [2:0] mask,
                      input bit acc, input bit last);
    lanes[0] = a0; lanes[1] = a1; lanes[2] = a2;
    for (int i = 0; i < NP; i++) port_id[i] = W'(lanes[i]);
    port_mask = mask; port_iv = 1'b1; acc_en = acc; port_ilast = last;
    step();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NP; i++) port_id[i] = W'($urandom);
      port_mask  = '1;
      port_iv    = 1'b0;
      acc_en     = 1'(($urandom));
      port_ilast = 1'(($urandom));
      step();
    end
  endtask

  task automatic rand_beat(input bit acc);
    logic [W-1:0] r;
    int           v[NP];
    for (int i = 0; i < NP; i++) begin
      r    = W'($urandom);
      v[i] = $signed(r);
    end
    beat(v[0], v[1], v[2], 3'($urandom), acc, $urandom_range(0, 2) == 0);
  endtask

  initial begin
    bit mode;
    rst = 1'b1; port_iv = 1'b0; port_ilast = 1'b0; acc_en = 1'b0;
    port_mask = '0; port_id = '0;
    for (int i = 0; i < NP; i++) lanes[i] = 0;
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);

    beat(5, -3, 7, 3'b111, 0, 0);               idle(4);
    beat(100, 200, -50, 3'b101, 0, 0);
    beat(100, 200, -50, 3'b000, 0, 0);          idle(4);
    beat(1, 0, 0, 3'b111, 0, 0);
    beat(-2, 0, 0, 3'b111, 0, 0);
    beat(262143, 0, 0, 3'b111, 0, 0);
    beat(-262144, 0, 0, 3'b111, 0, 0);          idle(4);
    beat(10, 0, 0, 3'b111, 1, 0);
    beat(20, 0, 0, 3'b111, 1, 0);
    beat(30, 0, 0, 3'b111, 1, 1);
    beat(4, 0, 0, 3'b111, 0, 0);                idle(4);
    beat(262143, 262143, 262143, 3'b111, 1, 0);
    beat(262143, 262143, 262143, 3'b111, 1, 1); idle(4);
    beat(-262144, -262144, -262144, 3'b111, 1, 0);
    beat(-262144, -262144, -262144, 3'b111, 1, 0);
    beat(5, 0, 0, 3'b111, 0, 0);                idle(4);
    beat(50, 0, 0, 3'b111, 1, 0);
    beat(50, 0, 0, 3'b111, 1, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    beat(7, 0, 0, 3'b111, 1, 1);                idle(4);

    mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c == 250) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) idle(1);
      else rand_beat(mode);
    end
    idle(LV + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
